// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory and
// presents {PC+4, instruction} to IF/ID, with a one-entry skid for stalled returns.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_valid_o
);

    typedef enum logic [1:0] {IDLE, FETCH, READY, DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;

    logic            req;
    logic            ack;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc_inc;

    assign req    = (state_q == FETCH) || (state_q == DROP);
    assign ack    = imem_ack_i & req;
    assign tgt    = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign pc_inc = pc_q + XLEN'(4);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc4_d  = skid_pc4_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                pc_d    = redirect_i ? tgt : pc_q;
                addr_d  = redirect_i ? tgt : pc_q;
            end
            FETCH: begin
                // In FETCH the request address always equals pc_q.
                if (redirect_i) begin
                    pc_d    = tgt;
                    valid_d = 1'b0;
                    inst_d  = '0;
                    if (ack) addr_d  = tgt;
                    else     state_d = DROP;
                end else if (ack && (!stall_i || !valid_q)) begin
                    inst_d  = imem_data_i;
                    pc4_d   = pc_inc;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                    addr_d  = pc_inc;
                end else if (ack) begin
                    skid_inst_d = imem_data_i;
                    skid_pc4_d  = pc_inc;
                    pc_d        = pc_inc;
                    addr_d      = pc_inc;
                    state_d     = READY;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    inst_d  = '0;
                end
            end
            READY: begin
                if (redirect_i) begin
                    pc_d    = tgt;
                    addr_d  = tgt;
                    valid_d = 1'b0;
                    inst_d  = '0;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    inst_d  = skid_inst_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DROP: begin
                // Stale request stays on the bus until its ack; only pc tracks redirects.
                if (redirect_i) pc_d = tgt;
                if (ack) begin
                    state_d = FETCH;
                    addr_d  = redirect_i ? tgt : pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            inst_q      <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            skid_inst_q <= '0;
            skid_pc4_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc4_q  <= skid_pc4_d;
        end
    end

    assign imem_req_o   = req;
    assign imem_addr_o  = addr_q;
    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc4_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed pipeline scenarios followed by a randomized
// run scored against an in-order program-stream model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] pc, pc4, inst;
    logic        valid;

    logic        req2, ack2;
    logic [31:0] addr2, data2, pc2, pc4_2, inst2;
    logic        valid2;

    always #5 clk = ~clk;

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(imem_ack), .imem_data_i(imem_data), .pc_o(pc),
        .pc_plus4_o(pc4), .inst_o(inst), .inst_valid_o(valid)
    );

    if_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_hi (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_ack_i(ack2), .imem_data_i(data2), .pc_o(pc2),
        .pc_plus4_o(pc4_2), .inst_o(inst2), .inst_valid_o(valid2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    // Memory: acks after cur_lat wait cycles; may raise a stray ack while req is low.
    int   cnt, rnd_lat, lat_cfg, cur_lat;
    logic lat_rand, spur;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= 0;
            rnd_lat <= 0;
        end else if (imem_req && imem_ack) begin
            cnt     <= 0;
            rnd_lat <= int'($urandom_range(0, 3));
        end else if (imem_req) cnt <= cnt + 1;
        else cnt <= 0;
    end
    assign cur_lat   = lat_rand ? rnd_lat : lat_cfg;
    assign imem_ack  = imem_req ? (cnt >= cur_lat) : spur;
    assign imem_data = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    assign ack2      = req2;
    assign data2     = mem_word(addr2);

    int passed = 0, failed = 0, total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_inst"}, inst, 32'd0);
        chk({tag, "_pc4"}, pc4, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    endtask

    // Random-phase scoreboard state
    logic [31:0] exp_pc, prev_inst, prev_pc4, prev_addr;
    logic        prev_hold, prev_wait;
    int          consumed;

    task automatic cyc(input logic st, input logic rd, input logic [31:0] tgt);
        stall = st; redirect = rd; redirect_pc = tgt;
        @(negedge clk);
        if (!valid) chk("nop_when_invalid", inst, 32'd0);
        if (prev_hold) begin
            chk("stall_hold_inst", inst, prev_inst);
            chk("stall_hold_pc4", pc4, prev_pc4);
            chk("stall_hold_valid", {31'd0, valid}, 32'd1);
        end
        if (prev_wait) begin
            chk("addr_stable", imem_addr, prev_addr);
            chk("req_stable", {31'd0, imem_req}, 32'd1);
        end
        if (rd) exp_pc = {tgt[31:2], 2'b00};
        else if (valid && !st) begin
            chk("stream_inst", inst, mem_word(exp_pc));
            chk("stream_pc4", pc4, exp_pc + 32'd4);
            exp_pc   = exp_pc + 32'd4;
            consumed = consumed + 1;
        end
        prev_hold = valid && st && !rd;
        prev_wait = imem_req && !imem_ack;
        prev_inst = inst;
        prev_pc4  = pc4;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        lat_cfg = 0; lat_rand = 1'b0; spur = 1'b0;
        #2;
        chk_reset("rst0");
        chk("hi_rst_pc", pc2, 32'hFFFF_FFF8);
        chk("hi_rst_addr", addr2, 32'hFFFF_FFF8);
        @(negedge clk) rst = 1'b0;

        // Zero-wait streaming, plus wrap on the high-reset instance
        tick();
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'd0);
        chk("t1_valid0", {31'd0, valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_addr", imem_addr, 32'(4 * (i + 1)));
            chk("t1_inst", inst, 32'h100 + 32'(4 * i));
            chk("t1_pc4", pc4, 32'(4 * i + 4));
            chk("t1_valid", {31'd0, valid}, 32'd1);
            if (i == 0) chk("t5_addr_fffc", addr2, 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("t5_addr_wrap", addr2, 32'h0000_0000);
                chk("t5_pc4_wrap", pc4_2, 32'h0000_0000);
                chk("t5_inst_fffc", inst2, 32'h0000_00FC);
            end
        end

        // Two-cycle ack latency: two bubbles per instruction, address held
        lat_cfg = 2;
        for (int j = 0; j < 2; j++) begin
            for (int b = 0; b < 2; b++) begin
                tick();
                chk("t2_bubble_valid", {31'd0, valid}, 32'd0);
                chk("t2_bubble_inst", inst, 32'd0);
                chk("t2_addr_hold", imem_addr, 32'(16 + 4 * j));
            end
            tick();
            chk("t2_inst", inst, mem_word(32'(16 + 4 * j)));
            chk("t2_pc4", pc4, 32'(20 + 4 * j));
        end

        // Stall with a return in flight: word parks in the skid buffer
        lat_cfg = 0;
        tick();
        chk("t3_pre_inst", inst, mem_word(32'd24));
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_hold_inst", inst, mem_word(32'd24));
            chk("t3_hold_pc4", pc4, 32'd28);
            chk("t3_ready_req", {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("t3_skid_inst", inst, mem_word(32'd28));
        chk("t3_skid_pc4", pc4, 32'd32);
        chk("t3_skid_valid", {31'd0, valid}, 32'd1);
        tick();
        chk("t3_next_inst", inst, mem_word(32'd32));
        chk("t3_next_pc4", pc4, 32'd36);

        // Redirect (with stall) while a 3-cycle fetch of 0x24 is pending
        lat_cfg = 3;
        tick();
        redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        chk("t4_drop_req", {31'd0, imem_req}, 32'd1);
        chk("t4_drop_addr", imem_addr, 32'd36);
        chk("t4_drop_pc", pc, 32'h40);
        chk("t4_drop_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("t4_drop_addr2", imem_addr, 32'd36);
        chk("t4_drop_valid2", {31'd0, valid}, 32'd0);
        tick();
        chk("t4_new_addr", imem_addr, 32'h40);
        chk("t4_new_valid", {31'd0, valid}, 32'd0);
        lat_cfg = 0;
        tick();
        chk("t4_new_inst", inst, mem_word(32'h40));
        chk("t4_new_pc4", pc4, 32'h44);

        // Asynchronous reset in READY
        stall = 1'b1;
        tick();
        chk("t6_ready_req", {31'd0, imem_req}, 32'd0);
        #3 rst = 1'b1;
        #1 chk_reset("t6_rst_ready");
        spur = 1'b1; stall = 1'b0;
        tick();
        @(negedge clk) rst = 1'b0;
        tick();
        chk("t6_restart_addr", imem_addr, 32'd0);
        chk("t6_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t6_restart_valid", {31'd0, valid}, 32'd0);
        spur = 1'b0;
        tick();
        chk("t6_restart_inst", inst, mem_word(32'd0));

        // Asynchronous reset in DROP
        lat_cfg = 3;
        redirect = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect = 1'b0;
        chk("t6_drop_addr", imem_addr, 32'd4);
        chk("t6_drop_pc", pc, 32'h80);
        #3 rst = 1'b1;
        #1 chk_reset("t6_rst_drop");
        lat_cfg = 0;
        tick();
        @(negedge clk) rst = 1'b0;
        tick();
        chk("t6_drop_restart_addr", imem_addr, 32'd0);
        tick();
        chk("t6_drop_restart_inst", inst, mem_word(32'd0));

        // Randomized run against the program-stream model
        rst = 1'b1;
        tick();
        @(negedge clk) rst = 1'b0;
        lat_rand = 1'b1;
        tick();
        exp_pc = 32'd0; prev_hold = 1'b0; prev_wait = 1'b0; consumed = 0;
        prev_inst = '0; prev_pc4 = '0; prev_addr = '0;
        for (int n = 0; n < 800; n++) begin
            spur = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0,
                32'($urandom_range(0, 1023)));
        end
        chk("rand_throughput", {31'd0, consumed >= 50}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
